// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI responder.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    localparam int BIT_CNT_W = bit_cnt_w(SPI_DATA_W);

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic {
        IDLE,
        XFER
    } spi_slv_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin followed by registered rise/fall detect.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              hist;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{RESET_VAL}};
            hist <= RESET_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            hist <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~hist;
            fall <= ~sync[STAGES-1] & hist;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled SCLK/SS_N/MOSI, MSB-first shift registers, buffered TX byte.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              sclk_i,
    input  logic              ss_ni,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_load_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_done_tick_o,
    output logic              underrun_tick_o,
    output logic              busy_o
);

    localparam int CNT_W = bit_cnt_w(DATA_W);

    spi_mode_t         mode;
    spi_slv_state_e    state, state_next;

    logic              sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic              mosi_s;

    logic [DATA_W-1:0] tx_shift, rx_shift, tx_buf;
    logic              tx_full;
    logic [CNT_W-1:0]  bit_cnt;
    logic              reload_armed, first_lead;

    logic              lead_edge, trail_edge, sample_edge, shift_edge;
    logic              start, abort, do_sample, do_shift, reload, skip_shift;
    logic              consume, load_ok, last_bit;

    assign mode.cpol = cpol_i;
    assign mode.cpha = cpha_i;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk_i),
        .rst_n (reset_ni),
        .din   (sclk_i),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // SS_N idles high, so its synchroniser resets high to avoid a false select.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk   (clk_i),
        .rst_n (reset_ni),
        .din   (ss_ni),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) mosi_sync <= '0;
        else           mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state <= IDLE;
        else           state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: if (ss_fall) begin
                state_next = XFER;
                start      = 1'b1;
            end
            XFER: if (ss_rise) begin
                state_next = IDLE;
                abort      = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        lead_edge   = mode.cpol ? sclk_fall : sclk_rise;
        trail_edge  = mode.cpol ? sclk_rise : sclk_fall;
        sample_edge = mode.cpha ? trail_edge : lead_edge;
        shift_edge  = mode.cpha ? lead_edge : trail_edge;

        do_sample  = (state == XFER) && !abort && sample_edge;
        do_shift   = (state == XFER) && !abort && shift_edge;
        reload     = do_shift && reload_armed;
        // With cpha=1 the first leading edge of a word keeps the MSB that was loaded at select.
        skip_shift = do_shift && mode.cpha && first_lead && !reload_armed;
        consume    = start || reload;
        load_ok    = tx_load_i && !tx_full;
        last_bit   = (bit_cnt == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tx_buf          <= '0;
            tx_full         <= 1'b0;
            tx_shift        <= '0;
            rx_shift        <= '0;
            rx_data_o       <= '0;
            rx_done_tick_o  <= 1'b0;
            underrun_tick_o <= 1'b0;
            bit_cnt         <= '0;
            reload_armed    <= 1'b0;
            first_lead      <= 1'b0;
        end else begin
            rx_done_tick_o  <= 1'b0;
            underrun_tick_o <= 1'b0;

            // A consume reads the old buffer; a same-cycle load refills it.
            if (load_ok) begin
                tx_buf  <= tx_data_i;
                tx_full <= 1'b1;
            end else if (consume) begin
                tx_full <= 1'b0;
            end

            if (consume) begin
                tx_shift        <= tx_full ? tx_buf : '0;
                underrun_tick_o <= !tx_full;
            end else if (do_shift && !skip_shift) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (start) begin
                bit_cnt      <= '0;
                reload_armed <= 1'b0;
                first_lead   <= 1'b1;
            end else if (abort) begin
                bit_cnt      <= '0;
                reload_armed <= 1'b0;
                first_lead   <= 1'b0;
            end else begin
                if (do_sample) begin
                    rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                    if (last_bit) begin
                        rx_data_o      <= {rx_shift[DATA_W-2:0], mosi_s};
                        rx_done_tick_o <= 1'b1;
                        bit_cnt        <= '0;
                        reload_armed   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                if (reload) reload_armed <= 1'b0;
                if (do_shift && mode.cpha) first_lead <= 1'b0;
            end
        end
    end

    assign busy_o     = (state == XFER);
    assign miso_oe_o  = (state == XFER);
    assign miso_o     = miso_oe_o ? tx_shift[DATA_W-1] : 1'b0;
    assign tx_ready_o = !tx_full;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: behavioural SPI master on the pins plus scoreboards for both data directions.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int DATA_W = 8;
    localparam int HALF   = 10;
    localparam int SETUP  = 8;

    logic              clk = 1'b0;
    logic              reset_ni = 1'b0;
    logic              cpol = 1'b0, cpha = 1'b0;
    logic              sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
    logic              miso, miso_oe;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_load = 1'b0;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done_tick, underrun_tick, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rx_ticks = 0;
    int n_underruns = 0;

    logic [DATA_W-1:0] exp_rx_q[$];
    logic [DATA_W-1:0] exp_miso_q[$];

    spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk_i           (clk),
        .reset_ni        (reset_ni),
        .cpol_i          (cpol),
        .cpha_i          (cpha),
        .sclk_i          (sclk),
        .ss_ni           (ss_n),
        .mosi_i          (mosi),
        .miso_o          (miso),
        .miso_oe_o       (miso_oe),
        .tx_data_i       (tx_data),
        .tx_load_i       (tx_load),
        .tx_ready_o      (tx_ready),
        .rx_data_o       (rx_data),
        .rx_done_tick_o  (rx_done_tick),
        .underrun_tick_o (underrun_tick),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_done_tick) begin
            n_rx_ticks++;
            check("rx_pending", 32'(exp_rx_q.size() != 0), 32'd1);
            if (exp_rx_q.size() != 0) check("slave_rx", rx_data, exp_rx_q.pop_front());
        end
        if (underrun_tick) n_underruns++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [DATA_W-1:0] v, input bit expect_on_miso);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        if (expect_on_miso) exp_miso_q.push_back(v);
    endtask

    task automatic set_mode(input int m);
        cpol = m[1];
        cpha = m[0];
        sclk = m[1];
        tick(4 * HALF);
    endtask

    task automatic select_slave();
        ss_n = 1'b0;
        tick(SETUP);
    endtask

    task automatic deselect_slave();
        tick(HALF);
        ss_n = 1'b1;
        tick(3 * HALF);
    endtask

    task automatic master_bits(input logic [DATA_W-1:0] tx, input int nbits, output logic [DATA_W-1:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = tx[DATA_W-1-i];
                tick(HALF);
                rx   = {rx[DATA_W-2:0], miso};
                sclk = ~cpol;
                tick(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = tx[DATA_W-1-i];
                tick(HALF);
                rx   = {rx[DATA_W-2:0], miso};
                sclk = cpol;
                tick(HALF);
            end
        end
    endtask

    task automatic master_word(input logic [DATA_W-1:0] tx);
        logic [DATA_W-1:0] rx;
        exp_rx_q.push_back(tx);
        master_bits(tx, DATA_W, rx);
        check("master_pending", 32'(exp_miso_q.size() != 0), 32'd1);
        if (exp_miso_q.size() != 0) check("master_rx", rx, exp_miso_q.pop_front());
    endtask

    task automatic wait_tick(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (rx_done_tick) seen = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_miso"},      miso,          0);
        check({pfx, "_miso_oe"},   miso_oe,       0);
        check({pfx, "_tx_ready"},  tx_ready,      1);
        check({pfx, "_rx_data"},   rx_data,       0);
        check({pfx, "_rx_done"},   rx_done_tick,  0);
        check({pfx, "_underrun"},  underrun_tick, 0);
        check({pfx, "_busy"},      busy,          0);
    endtask

    initial begin
        int                ticks0, unr0;
        bit                seen;
        logic [DATA_W-1:0] dummy, sum;
        logic [DATA_W-1:0] sent[3];

        tick(5);
        check_reset_outputs("rst");
        reset_ni = 1'b1;
        tick(5);

        // Mode 0 single word
        set_mode(0);
        ticks0 = n_rx_ticks;
        load_tx(8'h3C, 1'b1);
        check("m0_tx_ready_full", tx_ready, 0);
        select_slave();
        check("m0_busy", busy, 1);
        master_word(8'h05);
        deselect_slave();
        check("m0_rx_ticks", n_rx_ticks - ticks0, 1);
        check("m0_tx_ready_after", tx_ready, 1);
        check("m0_busy_after", busy, 0);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            set_mode(m);
            ticks0 = n_rx_ticks;
            load_tx(8'h5A, 1'b1);
            select_slave();
            master_word(8'hA5);
            deselect_slave();
            check("mode_rx_ticks", n_rx_ticks - ticks0, 1);
        end

        // Three back-to-back words, slave reloads the running sum after each tick
        set_mode(0);
        sent[0] = 8'h01; sent[1] = 8'h02; sent[2] = 8'h03;
        sum = 8'h00;
        ticks0 = n_rx_ticks;
        load_tx(sum, 1'b1);
        fork
            begin
                select_slave();
                for (int k = 0; k < 3; k++) master_word(sent[k]);
                deselect_slave();
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    wait_tick(seen);
                    check("mw_tick_seen", 32'(seen), 32'd1);
                    sum = sum + sent[k];
                    load_tx(sum, 1'b1);
                end
            end
        join
        check("mw_rx_ticks", n_rx_ticks - ticks0, 3);

        // Underrun: empty buffer at select, mode 1
        set_mode(1);
        check("ur_tx_ready", tx_ready, 1);
        unr0 = n_underruns;
        exp_miso_q.push_back(8'h00);
        select_slave();
        master_word(8'h33);
        deselect_slave();
        check("ur_pulses", n_underruns - unr0, 1);

        // Abort after 4 bits
        set_mode(0);
        ticks0 = n_rx_ticks;
        select_slave();
        master_bits(8'hF0, 4, dummy);
        deselect_slave();
        check("ab_rx_ticks", n_rx_ticks - ticks0, 0);
        check("ab_rx_data", rx_data, 8'h33);
        check("ab_busy", busy, 0);
        load_tx(8'h96, 1'b1);
        select_slave();
        master_word(8'h81);
        deselect_slave();
        check("ab_next_ticks", n_rx_ticks - ticks0, 1);

        // Reset mid-word
        load_tx(8'hAB, 1'b0);
        select_slave();
        load_tx(8'hCD, 1'b0);
        check("rs_tx_ready_full", tx_ready, 0);
        master_bits(8'hFF, 3, dummy);
        @(negedge clk);
        reset_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        ss_n = 1'b1;
        sclk = cpol;
        tick(5);
        reset_ni = 1'b1;
        tick(5);
        ticks0 = n_rx_ticks;
        load_tx(8'h11, 1'b1);
        select_slave();
        master_word(8'h7E);
        deselect_slave();
        check("rs_next_ticks", n_rx_ticks - ticks0, 1);

        check("rx_q_drained", exp_rx_q.size(), 0);
        check("miso_q_drained", exp_miso_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
